// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU.
// Stage 1 captures the opcode and operands on an issue strobe.
// Stage 2 computes the result and registers it with the flags and a
// one-cycle valid strobe.
// Optional feature: define ALU_PIPE_STICKY_EN to enable the sticky
// overflow flag alu_ps_avs. Without it, alu_ps_avs reads 0 and
// ps_alu_stky_clr is ignored.
module alu_pipe #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ps_alu_en,
    input  logic                  ps_alu_log,
    input  logic [1:0]            ps_alu_hc,
    input  logic [2:0]            ps_alu_sc,
    input  logic                  ps_alu_sat,
    input  logic [DATA_WIDTH-1:0] xb_dtx,
    input  logic [DATA_WIDTH-1:0] xb_dty,
    input  logic                  ps_alu_stky_clr,
    output logic [DATA_WIDTH-1:0] alu_xb_dt,
    output logic                  alu_xb_vld,
    output logic                  alu_ps_az,
    output logic                  alu_ps_an,
    output logic                  alu_ps_ac,
    output logic                  alu_ps_av,
    output logic                  alu_ps_avs
);
    localparam int W = DATA_WIDTH;

    // Opcode = {log, hc, sc}
    localparam logic [5:0] OP_ADD  = 6'b0_00_000;
    localparam logic [5:0] OP_SUB  = 6'b0_00_001;
    localparam logic [5:0] OP_ADC  = 6'b0_00_010;
    localparam logic [5:0] OP_SBC  = 6'b0_00_011;
    localparam logic [5:0] OP_COMP = 6'b0_00_101;
    localparam logic [5:0] OP_MIN  = 6'b0_01_001;
    localparam logic [5:0] OP_MAX  = 6'b0_01_011;
    localparam logic [5:0] OP_NEG  = 6'b0_10_001;
    localparam logic [5:0] OP_ABS  = 6'b0_11_001;
    localparam logic [5:0] OP_AND  = 6'b1_00_000;
    localparam logic [5:0] OP_OR   = 6'b1_00_001;
    localparam logic [5:0] OP_XOR  = 6'b1_00_010;
    localparam logic [5:0] OP_RAND = 6'b1_10_000;
    localparam logic [5:0] OP_ROR  = 6'b1_10_001;
    localparam logic [5:0] OP_NOT  = 6'b1_11_000;

    // Stage 1 registers
    logic         s1_vld_q;
    logic         s1_log_q;
    logic [1:0]   s1_hc_q;
    logic [2:0]   s1_sc_q;
    logic         s1_sat_q;
    logic [W-1:0] s1_x_q;
    logic [W-1:0] s1_y_q;

    // Stage 2 (output) registers and their next values
    logic [W-1:0] dt_q, dt_d;
    logic         az_q, az_d;
    logic         an_q, an_d;
    logic         ac_q, ac_d;
    logic         av_q, av_d;
    logic         vld_q;
    logic         avs_q;

    logic [5:0]   op;
    assign op = {s1_log_q, s1_hc_q, s1_sc_q};

    // Stage 1: capture the op on issue; unary ops leave Y untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q <= 1'b0;
            s1_log_q <= 1'b0;
            s1_hc_q  <= 2'b00;
            s1_sc_q  <= 3'b000;
            s1_sat_q <= 1'b0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
        end else begin
            s1_vld_q <= ps_alu_en;
            if (ps_alu_en) begin
                s1_log_q <= ps_alu_log;
                s1_hc_q  <= ps_alu_hc;
                s1_sc_q  <= ps_alu_sc;
                s1_sat_q <= ps_alu_sat;
                s1_x_q   <= xb_dtx;
                if (!ps_alu_hc[1]) begin
                    s1_y_q <= xb_dty;
                end
            end
        end
    end

    // Shared adder: every arithmetic op is a + b + cin in W+1 bits
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W:0]   add_sum;
    logic         add_cout;
    logic         add_cmsb;
    logic         add_ovf;
    logic         add_neg;
    logic [W-1:0] sat_val;
    logic         x_lt_y;

    // Adder operand selection: subtraction and negation use inverted
    // operands with carry-in; ADC/SBC take carry-in from the registered AC
    always_comb begin
        add_a   = s1_x_q;
        add_b   = s1_y_q;
        add_cin = 1'b0;
        case (op)
            OP_SUB: begin
                add_b   = ~s1_y_q;
                add_cin = 1'b1;
            end
            OP_ADC: begin
                add_cin = ac_q;
            end
            OP_SBC: begin
                add_b   = ~s1_y_q;
                add_cin = ac_q;
            end
            OP_NEG: begin
                add_a   = '0;
                add_b   = ~s1_x_q;
                add_cin = 1'b1;
            end
            OP_ABS: begin
                add_a   = '0;
                add_b   = s1_x_q[W-1] ? ~s1_x_q : s1_x_q;
                add_cin = s1_x_q[W-1];
            end
            default: begin
            end
        endcase
    end

    assign add_sum  = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign add_cout = add_sum[W];
    // Carry into the MSB recovered from the sum bit and the operand bits
    assign add_cmsb = add_sum[W-1] ^ add_a[W-1] ^ add_b[W-1];
    assign add_ovf  = add_cmsb ^ add_cout;
    // True sign: bit W of the sign-extended sum, which picks the clamp direction
    assign add_neg  = add_a[W-1] ^ add_b[W-1] ^ add_cout;
    assign sat_val  = add_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign x_lt_y   = $signed(s1_x_q) < $signed(s1_y_q);

    // Stage 2 next state: result and flags; COMP only touches flags,
    // undefined codes hold everything
    always_comb begin
        logic [W-1:0] res;
        logic         has_res;
        logic         res_c;
        logic         res_v;
        res     = dt_q;
        has_res = 1'b0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        dt_d    = dt_q;
        az_d    = az_q;
        an_d    = an_q;
        ac_d    = ac_q;
        av_d    = av_q;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_NEG, OP_ABS: begin
                res     = (s1_sat_q && add_ovf) ? sat_val : add_sum[W-1:0];
                res_c   = add_cout;
                res_v   = add_ovf;
                has_res = 1'b1;
            end
            OP_MIN: begin
                res     = x_lt_y ? s1_x_q : s1_y_q;
                has_res = 1'b1;
            end
            OP_MAX: begin
                res     = x_lt_y ? s1_y_q : s1_x_q;
                has_res = 1'b1;
            end
            OP_AND: begin
                res     = s1_x_q & s1_y_q;
                has_res = 1'b1;
            end
            OP_OR: begin
                res     = s1_x_q | s1_y_q;
                has_res = 1'b1;
            end
            OP_XOR: begin
                res     = s1_x_q ^ s1_y_q;
                has_res = 1'b1;
            end
            OP_RAND: begin
                res     = {{(W-1){1'b0}}, &s1_x_q};
                has_res = 1'b1;
            end
            OP_ROR: begin
                res     = {{(W-1){1'b0}}, |s1_x_q};
                has_res = 1'b1;
            end
            OP_NOT: begin
                res     = ~s1_x_q;
                has_res = 1'b1;
            end
            OP_COMP: begin
                az_d = (s1_x_q == s1_y_q);
                an_d = x_lt_y;
                ac_d = 1'b0;
                av_d = 1'b0;
            end
            default: begin
            end
        endcase
        if (has_res) begin
            dt_d = res;
            az_d = (res == '0);
            an_d = res[W-1];
            ac_d = res_c;
            av_d = res_v;
        end
    end

    // Stage 2: retire the op held in stage 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dt_q  <= '0;
            az_q  <= 1'b0;
            an_q  <= 1'b0;
            ac_q  <= 1'b0;
            av_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                dt_q <= dt_d;
                az_q <= az_d;
                an_q <= an_d;
                ac_q <= ac_d;
                av_q <= av_d;
            end
        end
    end

`ifdef ALU_PIPE_STICKY_EN
    // Sticky overflow: set by any retire with AV=1, set beats clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avs_q <= 1'b0;
        end else if (s1_vld_q && av_d) begin
            avs_q <= 1'b1;
        end else if (ps_alu_stky_clr) begin
            avs_q <= 1'b0;
        end
    end
`else
    logic unused_stky_clr;
    assign unused_stky_clr = ps_alu_stky_clr;
    assign avs_q = 1'b0;
`endif

    assign alu_xb_dt  = dt_q;
    assign alu_xb_vld = vld_q;
    assign alu_ps_az  = az_q;
    assign alu_ps_an  = an_q;
    assign alu_ps_ac  = ac_q;
    assign alu_ps_av  = av_q;
    assign alu_ps_avs = avs_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: directed checks with hand-computed values,
// then randomized traffic compared every cycle against a behavioural model.
module tb_alu_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ps_alu_en = 1'b0;
    logic         ps_alu_log = 1'b0;
    logic [1:0]   ps_alu_hc = 2'b00;
    logic [2:0]   ps_alu_sc = 3'b000;
    logic         ps_alu_sat = 1'b0;
    logic [W-1:0] xb_dtx = '0;
    logic [W-1:0] xb_dty = '0;
    logic         ps_alu_stky_clr = 1'b0;
    logic [W-1:0] alu_xb_dt;
    logic         alu_xb_vld;
    logic         alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_avs;

    alu_pipe #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log),
        .ps_alu_hc(ps_alu_hc), .ps_alu_sc(ps_alu_sc), .ps_alu_sat(ps_alu_sat),
        .xb_dtx(xb_dtx), .xb_dty(xb_dty), .ps_alu_stky_clr(ps_alu_stky_clr),
        .alu_xb_dt(alu_xb_dt), .alu_xb_vld(alu_xb_vld), .alu_ps_az(alu_ps_az),
        .alu_ps_an(alu_ps_an), .alu_ps_ac(alu_ps_ac), .alu_ps_av(alu_ps_av),
        .alu_ps_avs(alu_ps_avs)
    );

    always #5 clk = ~clk;

`ifdef ALU_PIPE_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    typedef struct packed {
        logic         lg;
        logic [1:0]   hc;
        logic [2:0]   sc;
        logic         sat;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } op_t;

    typedef struct packed {
        logic [W-1:0] dt;
        logic         z, n, c, v;
    } res_t;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    function automatic longint sval(input logic [W-1:0] a);
        longint r;
        r = longint'(a);
        if (a[W-1]) r = r - (longint'(1) << W);
        return r;
    endfunction

    // Behavioural model of one retiring op, from the arithmetic definitions
    function automatic res_t model_op(input op_t o, input res_t prev);
        longint mx, smax, smin, sx, sy, ux, uy, cin, t, u;
        logic [5:0] code;
        logic [W-1:0] tw;
        int kind;
        res_t r;
        mx = (longint'(1) << W) - 1;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        sx = sval(o.x); sy = sval(o.y);
        ux = longint'(o.x); uy = longint'(o.y);
        cin = prev.c ? 1 : 0;
        t = 0; u = 0; kind = 0;
        r = prev;
        code = {o.lg, o.hc, o.sc};
        case (code)
            6'b000000: begin t = sx + sy;           u = ux + uy;            kind = 1; end
            6'b000001: begin t = sx - sy;           u = ux + (mx - uy) + 1; kind = 1; end
            6'b000010: begin t = sx + sy + cin;     u = ux + uy + cin;      kind = 1; end
            6'b000011: begin t = sx - sy + cin - 1; u = ux + (mx - uy) + cin; kind = 1; end
            6'b000101: kind = 3;
            6'b001001: begin t = (sx < sy) ? sx : sy; kind = 2; end
            6'b001011: begin t = (sx < sy) ? sy : sx; kind = 2; end
            6'b010001: begin t = -sx; u = (mx - ux) + 1; kind = 1; end
            6'b011001: begin
                t = (sx < 0) ? -sx : sx;
                u = (sx < 0) ? (mx - ux) + 1 : ux;
                kind = 1;
            end
            6'b100000: begin t = ux & uy; kind = 2; end
            6'b100001: begin t = ux | uy; kind = 2; end
            6'b100010: begin t = ux ^ uy; kind = 2; end
            6'b110000: begin t = (ux == mx) ? 1 : 0; kind = 2; end
            6'b110001: begin t = (ux != 0) ? 1 : 0; kind = 2; end
            6'b111000: begin t = mx - ux; kind = 2; end
            default: kind = 0;
        endcase
        if (kind == 1) begin
            r.c = ((u >> W) & 1) != 0;
            r.v = (t > smax) || (t < smin);
            if (r.v && o.sat) t = (t > smax) ? smax : smin;
        end else if (kind == 2) begin
            r.c = 1'b0;
            r.v = 1'b0;
        end
        if (kind == 1 || kind == 2) begin
            tw = t[W-1:0];
            r.dt = tw;
            r.z = (tw == '0);
            r.n = tw[W-1];
        end else if (kind == 3) begin
            r.z = (sx == sy);
            r.n = (sx < sy);
            r.c = 1'b0;
            r.v = 1'b0;
        end
        return r;
    endfunction

    function automatic logic avs_next(input logic retire, input op_t o, input res_t prev,
                                      input logic avs, input logic clr);
        res_t r;
        logic nv;
        r = retire ? model_op(o, prev) : prev;
        nv = (retire && r.v) ? 1'b1 : (clr ? 1'b0 : avs);
        return STICKY_ON ? nv : 1'b0;
    endfunction

    function automatic op_t cur_op(input logic [W-1:0] old_y);
        op_t o;
        o.lg = ps_alu_log; o.hc = ps_alu_hc; o.sc = ps_alu_sc; o.sat = ps_alu_sat;
        o.x = xb_dtx;
        o.y = ps_alu_hc[1] ? old_y : xb_dty;
        return o;
    endfunction

    // Model state: the op waiting to retire, and the architectural outputs
    logic p_vld;
    op_t  p_op;
    res_t m_res;
    logic m_vld;
    logic m_avs;

    // Model: an issued op retires on the following edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_vld <= 1'b0;
            p_op  <= '0;
            m_res <= '0;
            m_vld <= 1'b0;
            m_avs <= 1'b0;
        end else begin
            m_vld <= p_vld;
            if (p_vld) m_res <= model_op(p_op, m_res);
            m_avs <= avs_next(p_vld, p_op, m_res, m_avs, ps_alu_stky_clr);
            p_vld <= ps_alu_en;
            if (ps_alu_en) p_op <= cur_op(p_op.y);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, exp);
        end
    endtask

    // Per-cycle compare against the model, just after each edge
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (chk_en) begin
            chk("cyc_vld", {31'b0, alu_xb_vld}, {31'b0, m_vld});
            chk("cyc_dt", {16'b0, alu_xb_dt}, {16'b0, m_res.dt});
            chk("cyc_flags", {28'b0, alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av},
                {28'b0, m_res.z, m_res.n, m_res.c, m_res.v});
            chk("cyc_avs", {31'b0, alu_ps_avs}, {31'b0, m_avs});
        end
    end

    task automatic drive(input logic [5:0] code, input logic sat,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        ps_alu_en = 1'b1;
        ps_alu_log = code[5];
        ps_alu_hc = code[4:3];
        ps_alu_sc = code[2:0];
        ps_alu_sat = sat;
        xb_dtx = x;
        xb_dty = y;
        @(negedge clk);
        ps_alu_en = 1'b0;
    endtask

    task automatic idle();
        ps_alu_en = 1'b0;
        @(negedge clk);
    endtask

    // Directed expectation: DUT outputs and the model both pinned to literals
    task automatic expect_out(input string nm, input logic [W-1:0] dt,
                              input logic z, input logic n, input logic c, input logic v);
        $display("op %s: dt=%h z%0b n%0b c%0b v%0b vld%0b avs%0b", nm, alu_xb_dt,
                 alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_xb_vld, alu_ps_avs);
        chk({nm, "_vld"}, {31'b0, alu_xb_vld}, 32'd1);
        chk({nm, "_dt"}, {16'b0, alu_xb_dt}, {16'b0, dt});
        chk({nm, "_flags"}, {28'b0, alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av},
            {28'b0, z, n, c, v});
        chk({nm, "_model"}, {12'b0, m_res.dt, m_res.z, m_res.n, m_res.c, m_res.v},
            {12'b0, dt, z, n, c, v});
    endtask

    function automatic logic [5:0] code_of(input int i);
        case (i)
            0: return 6'b000000;  1: return 6'b000001;  2: return 6'b000010;
            3: return 6'b000011;  4: return 6'b000101;  5: return 6'b001001;
            6: return 6'b001011;  7: return 6'b010001;  8: return 6'b011001;
            9: return 6'b100000;  10: return 6'b100001; 11: return 6'b100010;
            12: return 6'b110000; 13: return 6'b110001; 14: return 6'b111000;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return {1'b0, {(W-1){1'b1}}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {W{1'b1}};
            4: return {{(W-1){1'b0}}, 1'b1};
            default: return W'($urandom);
        endcase
    endfunction

    localparam logic [5:0] C_ADD = 6'b000000, C_SUB = 6'b000001, C_ADC = 6'b000010;
    localparam logic [5:0] C_COMP = 6'b000101, C_MIN = 6'b001001, C_MAX = 6'b001011;
    localparam logic [5:0] C_NEG = 6'b010001, C_ABS = 6'b011001, C_RAND = 6'b110000;
    localparam logic [5:0] C_ROR = 6'b110001, C_NOT = 6'b111000, C_UNDEF = 6'b001000;

    initial begin
        int vld_seen;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_state", {12'b0, alu_xb_dt, alu_xb_vld, alu_ps_az, alu_ps_an, alu_ps_ac},
            {12'b0, 16'h0000, 4'b0000});

        drive(C_ADD, 1'b0, 16'h7FFF, 16'h0001); idle();
        expect_out("add_ovf", 16'h8000, 0, 1, 0, 1);
`ifndef ALU_PIPE_STICKY_EN
        chk("avs_tied_low", {31'b0, alu_ps_avs}, 32'd0);
`endif
        drive(C_ADD, 1'b1, 16'h7FFF, 16'h0001); idle();
        expect_out("add_sat", 16'h7FFF, 0, 0, 0, 1);
        drive(C_SUB, 1'b1, 16'h8000, 16'h0001); idle();
        expect_out("sub_sat", 16'h8000, 0, 1, 1, 1);

        drive(C_ADD, 1'b0, 16'hFFFF, 16'h0001);
        drive(C_ADC, 1'b0, 16'h0001, 16'h0001);
        expect_out("add_carry", 16'h0000, 1, 0, 1, 0);
        idle();
        expect_out("adc_chain", 16'h0003, 0, 0, 0, 0);

        drive(C_COMP, 1'b0, 16'hFFFE, 16'h0003); idle();
        expect_out("comp", 16'h0003, 0, 1, 0, 0);
        drive(C_MAX, 1'b0, 16'h8000, 16'h0001); idle();
        expect_out("max", 16'h0001, 0, 0, 0, 0);
        drive(C_MIN, 1'b0, 16'h7FFF, 16'h8000); idle();
        expect_out("min", 16'h8000, 0, 1, 0, 0);

        drive(C_ABS, 1'b1, 16'h8000, 16'h1234); idle();
        expect_out("abs_sat", 16'h7FFF, 0, 0, 0, 1);
        drive(C_ROR, 1'b0, 16'h0040, 16'h0000); idle();
        expect_out("red_or", 16'h0001, 0, 0, 0, 0);
        drive(C_NOT, 1'b0, 16'h00FF, 16'h0000); idle();
        expect_out("not", 16'hFF00, 0, 1, 0, 0);
        drive(C_UNDEF, 1'b0, 16'h1111, 16'h2222); idle();
        expect_out("undef_hold", 16'hFF00, 0, 1, 0, 0);
        drive(C_NEG, 1'b0, 16'h0000, 16'h0000); idle();
        expect_out("neg_zero", 16'h0000, 1, 0, 1, 0);
        drive(C_RAND, 1'b0, 16'hFFFF, 16'h0000); idle();
        expect_out("red_and", 16'h0001, 0, 0, 0, 0);

`ifdef ALU_PIPE_STICKY_EN
        ps_alu_stky_clr = 1'b1; idle(); ps_alu_stky_clr = 1'b0;
        chk("avs_clr0", {31'b0, alu_ps_avs}, 32'd0);
        drive(C_ADD, 1'b0, 16'h7FFF, 16'h0001); idle();
        chk("avs_set", {31'b0, alu_ps_avs}, 32'd1);
        drive(C_ADD, 1'b0, 16'h0001, 16'h0001); idle();
        chk("avs_hold", {31'b0, alu_ps_avs}, 32'd1);
        ps_alu_stky_clr = 1'b1; idle(); ps_alu_stky_clr = 1'b0;
        chk("avs_clr", {31'b0, alu_ps_avs}, 32'd0);
        drive(C_ADD, 1'b0, 16'h7FFF, 16'h0001);
        ps_alu_stky_clr = 1'b1; idle(); ps_alu_stky_clr = 1'b0;
        chk("avs_set_wins", {31'b0, alu_ps_avs}, 32'd1);
`endif

        // Reset one cycle after issue: the op never retires
        drive(C_ADD, 1'b0, 16'h0001, 16'h0001);
        reset = 1'b0;
        #1;
        chk("rst_outputs", {9'b0, alu_xb_dt, alu_xb_vld, alu_ps_az, alu_ps_an,
            alu_ps_ac, alu_ps_av, alu_ps_avs, 1'b0}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        vld_seen = 0;
        repeat (3) begin
            idle();
            if (alu_xb_vld) vld_seen++;
        end
        chk("rst_no_vld", 32'(vld_seen), 32'd0);
        chk("rst_dt", {16'b0, alu_xb_dt}, 32'd0);

        // Randomized traffic; the per-cycle compare checks every cycle
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] code;
            code = code_of($urandom_range(0, 15));
            ps_alu_en = ($urandom_range(0, 3) != 0);
            ps_alu_log = code[5];
            ps_alu_hc = code[4:3];
            ps_alu_sc = code[2:0];
            ps_alu_sat = $urandom_range(0, 1) == 1;
            xb_dtx = rnd_val();
            xb_dty = rnd_val();
            ps_alu_stky_clr = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 499) != 0);
            @(negedge clk);
            reset = 1'b1;
        end
        ps_alu_en = 1'b0;
        ps_alu_stky_clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage pipelined, width-parametrised successor to the datapath ALU. It captures operands and opcode from the crossbar/program sequencer in stage 1 and computes the result in stage 2. Result and flags are registered, and each result is marked with a valid strobe. It also fixes signed overflow, saturation direction and compare semantics, and adds an optional sticky-overflow flag for the sequencer's status register.

## Interface
- DATA_WIDTH, 16, operand/result width (≥4)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- ps_alu_en  in  1  issue strobe; one op per asserted cycle
- ps_alu_log  in  1  1 = logic group, 0 = arithmetic group
- ps_alu_hc  in  2  opcode high field
- ps_alu_sc  in  3  opcode sub field
- ps_alu_sat  in  1  saturate this op on overflow
- xb_dtx  in  DATA_WIDTH  operand X
- xb_dty  in  DATA_WIDTH  operand Y
- ps_alu_stky_clr  in  1  clear sticky overflow
- alu_xb_dt  out  DATA_WIDTH  result register
- alu_xb_vld  out  1  one-cycle pulse when an op retires
- alu_ps_az / alu_ps_an / alu_ps_ac / alu_ps_av  out  1 each  zero, negative, carry, overflow
- alu_ps_avs  out  1  sticky overflow

## Operation
- Stage 1 (issue edge): on ps_alu_en=1, latch log/hc/sc/sat and X. Latch Y only when ps_alu_hc[1]=0, because unary ops keep the old Y.
- Stage 2 (next edge): compute, then register alu_xb_dt, the flags and alu_xb_vld=1.
- Arithmetic group (log=0):
  - hc00, sc000: X+Y
  - hc00, sc001: X−Y
  - hc00, sc010: X+Y+AC
  - hc00, sc011: X−Y+AC−1
  - hc00, sc101: COMP. Flags only; alu_xb_dt holds.
  - hc01, sc001: MIN (signed)
  - hc01, sc011: MAX (signed)
  - hc10, sc001: −X
  - hc11, sc001: ABS X
- Logic group (log=1):
  - hc00, sc000: AND
  - hc00, sc001: OR
  - hc00, sc010: XOR
  - hc10, sc000: reduce-AND X, zero-extended
  - hc10, sc001: reduce-OR X, zero-extended
  - hc11, sc000: NOT X
- Undefined codes retire as a no-op: vld pulses; result and flags hold.
- Arithmetic is done in DATA_WIDTH+1 bits.
- Flags for arithmetic ops:
  - AC = carry out of MSB.
  - AV = carry into MSB XOR carry out of MSB.
  - −X and ABS of the most-negative value set AV=1.
  - MIN/MAX use a true signed comparison, never the sign of the difference, and set AC=AV=0.
- Flags for logic ops: AC=AV=0.
- Flags for COMP: AZ=(X==Y), AN=(X<Y signed), AC=AV=0.
- Saturation: if the latched sat=1 and AV=1, the result becomes 0111…1 for positive overflow and 1000…0 for negative overflow. Direction is taken from the true sign, i.e. bit DATA_WIDTH of the extended sum. AV stays 1.
- AZ and AN are computed from the final, post-saturation result.
- The AC used by ADC/SBC is the registered alu_ps_ac. Back-to-back ops see the previous op's carry with no hazard: op N's flags register on the same edge that op N+1 enters stage 2.

## Timing
- Latency is 2 edges: issue at cycle N, vld and result visible after edge N+2.
- Throughput is 1 op per cycle.
- Reset asserted: all outputs, stage registers and sticky flag go to 0 immediately. In-flight ops are discarded, and no vld is produced for them.
- ps_alu_en=0: stage 1 holds its contents and stage 2 does not retire, so vld=0 and result and flags hold.
- Sticky overflow set and clear in the same cycle: set wins.

## Configuration
- ALU_PIPE_STICKY_EN defined: alu_ps_avs is set on any retire with AV=1. It stays set until a ps_alu_stky_clr edge or reset.
- ALU_PIPE_STICKY_EN not defined: alu_ps_avs is tied to 0 and ps_alu_stky_clr is ignored. The ports remain.

## Test plan
- **Signed add overflow, no saturation.** Reset, then issue ADD 0x7FFF+0x0001 with sat=0. Two cycles later: vld=1, result 0x8000, AV=1, AN=1, AC=0, AZ=0.
- **Saturation.** Issue the same ADD with sat=1: result 0x7FFF, AV=1, AN=0. Issue SUB 0x8000−0x0001 with sat=1: result 0x8000, AV=1.
- **Carry chain.** Back-to-back issue of ADD 0xFFFF+0x0001 and ADC 0x0001+0x0001. First retire: result 0, AZ=1, AC=1. Next cycle: result 0x0003, AC=0.
- **Compare and signed MIN/MAX.** Issue COMP X=0xFFFE, Y=0x0003: AN=1, AZ=0, result unchanged. Issue MAX 0x8000,0x0001: result 0x0001. Issue MIN 0x7FFF,0x8000: result 0x8000.
- **Unary ops.** Issue ABS 0x8000 with sat=1: result 0x7FFF, AV=1. Issue reduce-OR 0x0040: result 0x0001. Issue NOT 0x00FF: result 0xFF00, AN=1.
- **Sticky flag and reset.** With ALU_PIPE_STICKY_EN, an overflow op sets avs=1; avs holds through a following clean ADD, and clr drops it. Asserting reset one cycle after issue means no vld ever appears and all outputs read 0.
